uart_rx_sequencer: RTL
======================

# uart_rx_sequencer

Serial receive sequencer that owns the oversample counter, bit counter and shift register of the UART receive path, and turns a synchronized serial line into parallel bytes. It validates the start bit at mid-bit, samples data LSB-first at bit centres and checks the stop bit. It presents each byte on a valid/ready holding register with frame-error and overrun reporting. It sits between the input synchronizer/baud-tick generator and the receive FIFO.

## Interface
- DATA_BITS, 8, data bits per frame (5..9)
- OVERSAMPLE, 16, ticks per bit; even, >= 4
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- tick  input  1  oversample enable, OVERSAMPLE pulses per bit time
- rx  input  1  serial line, already synchronized, idle high
- rx_en  input  1  enables start-bit detection
- data  output  DATA_BITS  received byte, valid while data_valid=1
- data_valid  output  1  holding register full
- data_ready  input  1  consumer accepts data when data_valid & data_ready
- frame_error  output  1  one-cycle pulse, stop bit sampled low
- parity_error  output  1  one-cycle pulse, parity mismatch (0 unless RX_PARITY_EN)
- overrun  output  1  one-cycle pulse, completed frame dropped because register full
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, START, DATA, (PARITY), STOP, BREAK. Counters advance only on cycles with tick=1.
- clk_cnt width $clog2(OVERSAMPLE); bit_cnt width $clog2(DATA_BITS+1); both cleared on every state entry.
- IDLE: if rx_en & tick & rx==0 -> START.
- START: on the tick where clk_cnt==OVERSAMPLE/2-1, sample rx: 0 -> DATA, 1 -> IDLE (glitch, no output). Otherwise clk_cnt++.
- DATA: on the tick where clk_cnt==OVERSAMPLE-1, shift rx into MSB of shift register (right shift, LSB-first line order), bit_cnt++, clk_cnt wraps to 0; after bit DATA_BITS-1 -> PARITY if configured, else STOP.
- PARITY: one bit time; sample compared with even parity of the shifted data; result latched for STOP.
- STOP: at clk_cnt==OVERSAMPLE-1, sample rx:
  - rx=1, parity ok -> deliver frame, -> IDLE.
  - rx=1, parity bad -> parity_error pulse, discard, -> IDLE.
  - rx=0 -> frame_error pulse, discard (parity not reported), -> BREAK.
- BREAK: wait for rx==1 on a tick, then -> IDLE (no start detection while line held low).
- Deliver: if data_valid==0, or data_ready==1 in the same cycle, load data, data_valid=1. Otherwise overrun pulse; old data retained, new data dropped.
- data_valid clears the cycle after data_valid & data_ready, unless a simultaneous delivery reloads it.
- rx_en deasserted mid-frame: current frame completes normally; only new starts are blocked.

## Timing
- Reset (async, immediate): state IDLE, counters 0, shift register 0, data=0, data_valid=0, frame_error=0, parity_error=0, overrun=0, busy=0.
- Start sampled OVERSAMPLE/2 ticks after the falling-edge tick; each subsequent sample OVERSAMPLE ticks later (bit centre).
- data_valid / frame_error / parity_error / overrun register the cycle after the stop-bit sampling tick.
- Pulses are exactly one clk wide regardless of tick rate.
- busy asserts the cycle after start detection and drops on IDLE entry.
- Back-to-back frames: a new start is detectable on the first tick in IDLE after stop delivery.

## Configuration
- RX_PARITY_EN defined: PARITY state present, one even-parity bit between data and stop, parity_error driven as described.
- Undefined: no PARITY state, DATA -> STOP directly, parity_error tied 0; frame length 1+DATA_BITS+1 bits.

## Test plan
- OVERSAMPLE=16, tick every cycle, data_ready=1, send 0xA5 -> one data_valid cycle with data=0xA5, no error pulses, busy low afterward.
- rx low for 4 ticks then high -> returns to IDLE at mid-start tick 8, data_valid never asserts, busy pulses only.
- Send 0x3C with stop bit 0, then hold rx low 40 ticks -> single frame_error pulse, no data_valid, no new start until rx high; next 0x81 received correctly.
- data_ready=0, send 0x11 then 0x22 -> data=0x11 valid held, overrun pulse at second frame end, data stays 0x11; raise data_ready -> data_valid drops next cycle.
- Assert reset_n low mid data bit 4 -> all outputs 0 immediately; after release, 0x5A received correctly.
- RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_error pulse, no data_valid; with parity bit 1 -> data=0x07 delivered.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: oversampled UART receive FSM that turns a synchronized serial line into parallel bytes.
// Latency: busy rises one clk after start detection; data_valid/error pulses rise one clk after the stop-bit sampling tick.
// Backpressure: single valid/ready holding register; a frame completing while it is full is dropped and flagged as overrun.
// Optional feature: define RX_PARITY_EN to add one even-parity bit between data and stop (drives parity_error).

module uart_rx_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Mid-bit point used to qualify the start bit, and end-of-bit point used
  // for every later sample (which lands on the bit centre).
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          clk_cnt_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   data_valid_q;
  logic                   frame_error_q;
  logic                   overrun_q;
  logic                   busy_q;
`ifdef RX_PARITY_EN
  logic                   parity_error_q;
  logic                   par_bad_q;
`endif

  // Receive FSM with counters, shift register, holding register and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      clk_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
`ifdef RX_PARITY_EN
      parity_error_q <= 1'b0;
      par_bad_q      <= 1'b0;
`endif
    end else begin
      // Status flags are single-clk pulses regardless of tick rate.
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef RX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
      // Consumer handshake empties the holding register; a delivery in the
      // same cycle (below) overrides this and reloads it.
      if (data_valid_q && data_ready) begin
        data_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (rx_en && tick && !rx) begin
            state_q   <= ST_START;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end

        ST_START: begin
          if (tick) begin
            if (clk_cnt_q == CNT_MID) begin
              clk_cnt_q <= '0;
              bit_cnt_q <= '0;
              if (!rx) begin
                state_q <= ST_DATA;
              end else begin
                // Line went back high before mid-bit: treat as a glitch.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              clk_cnt_q <= clk_cnt_q + CW'(1);
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (clk_cnt_q == CNT_END) begin
              clk_cnt_q <= '0;
              // LSB arrives first, so shift right and insert at the top.
              shift_q   <= {rx, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_q <= '0;
`ifdef RX_PARITY_EN
                state_q   <= ST_PARITY;
`else
                state_q   <= ST_STOP;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
              end
            end else begin
              clk_cnt_q <= clk_cnt_q + CW'(1);
            end
          end
        end

`ifdef RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (clk_cnt_q == CNT_END) begin
              clk_cnt_q <= '0;
              bit_cnt_q <= '0;
              // Even parity: the parity bit equals the XOR of the data bits.
              par_bad_q <= rx ^ (^shift_q);
              state_q   <= ST_STOP;
            end else begin
              clk_cnt_q <= clk_cnt_q + CW'(1);
            end
          end
        end
`endif

        ST_STOP: begin
          if (tick) begin
            if (clk_cnt_q == CNT_END) begin
              clk_cnt_q <= '0;
              bit_cnt_q <= '0;
              if (rx) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
`ifdef RX_PARITY_EN
                if (par_bad_q) begin
                  parity_error_q <= 1'b1;
                end else
`endif
                if (!data_valid_q || data_ready) begin
                  data_q       <= shift_q;
                  data_valid_q <= 1'b1;
                end else begin
                  // Holding register still owned by the consumer: keep old byte.
                  overrun_q <= 1'b1;
                end
              end else begin
                // Stop bit low: framing error, parity result is not reported.
                frame_error_q <= 1'b1;
                state_q       <= ST_BREAK;
              end
            end else begin
              clk_cnt_q <= clk_cnt_q + CW'(1);
            end
          end
        end

        ST_BREAK: begin
          // Stay here while the line is held low so a break is not read as starts.
          if (tick && rx) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;
`ifdef RX_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule
